// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, derived totals, coordinate width and a span helper.
// Contents: VGA_H_/VGA_V_ DISPLAY/FRONT/SYNC/BACK defaults for 640x480@60,
//           VGA_H_TOTAL/VGA_V_TOTAL, COORD_W (also used by the glyph renderers),
//           in_span(v, lo, len) -> 1 when lo <= v < lo+len.
package vga_pkg;
  localparam int COORD_W = 10;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  function automatic logic in_span(logic [COORD_W-1:0] v, int lo, int len);
    return int'(v) >= lo && int'(v) < lo + len;
  endfunction
endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock by CLK_DIV into a one-clock pixel enable.
// Ports: clk (system clock), reset (async, active-high),
//        p_tick (high in the clock where the divider sits at CLK_DIV-1).
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  always_ff @(posedge clk or posedge reset)
    if (reset) div <= '0;
    else div <= (div == LAST) ? '0 : div + DW'(1);
  // With CLK_DIV=1 div always equals LAST, so reset gating is what keeps p_tick low in reset
  // while still letting the first pixel advance one clock after release.
  assign p_tick = (div == LAST) && !reset;
endmodule

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 VGA timing generator (pixel coordinates, syncs, pixel/frame ticks).
// Ports: clk, reset (async, active-high); x/y current pixel; video_on visible-area flag;
//        hsync/vsync (asserted level SYNC_ACTIVE); p_tick pixel enable;
//        frame_tick one-clock pulse on wrap to (0,0); frame_cnt frame counter.
// Build option: define VGA_SYNC_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is 0.
module vga_sync
  import vga_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               p_tick,
  output logic               frame_tick,
  output logic [15:0]        frame_cnt
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_cfg_err
    $error("vga_sync: H_TOTAL/V_TOTAL must not exceed 1024 and CLK_DIV must be >= 1");
  end
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .p_tick(p_tick));
  logic x_end, y_end, wrap;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  always_comb begin
    x_end = x == X_LAST;
    y_end = y == Y_LAST;
    wrap = p_tick && x_end && y_end;
    x_nxt = !p_tick ? x : x_end ? '0 : x + COORD_W'(1);
    y_nxt = !(p_tick && x_end) ? y : y_end ? '0 : y + COORD_W'(1);
  end
  // Flags are decoded from the next coordinates so they change on the same edge as x/y.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x <= '0;
      y <= '0;
      video_on <= 1'b1;
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
      frame_tick <= 1'b0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
      video_on <= in_span(x_nxt, 0, H_DISPLAY) && in_span(y_nxt, 0, V_DISPLAY);
      hsync <= in_span(x_nxt, H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync <= in_span(y_nxt, V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_tick <= wrap;
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) frame_cnt <= '0;
    else if (wrap) frame_cnt <= frame_cnt + 16'd1;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: self-checking bench for vga_sync (default, small CLK_DIV=4 and small CLK_DIV=1 builds).
module tb_vga_sync;
  localparam int S_DIV = 4, S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2, S_VD = 5, S_VF = 1, S_VS = 2, S_VB = 1;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic vo, hs, vs, pt, ft;
    logic [15:0] fc;
  } obs_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] x[3], y[3];
  logic vo[3], hs[3], vs[3], pt[3], ft[3];
  logic [15:0] fc[3];
  int n = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset) n <= reset ? 0 : n + 1;
  vga_sync u_d0 (.clk(clk), .reset(reset), .x(x[0]), .y(y[0]), .video_on(vo[0]), .hsync(hs[0]),
    .vsync(vs[0]), .p_tick(pt[0]), .frame_tick(ft[0]), .frame_cnt(fc[0]));
  vga_sync #(.CLK_DIV(S_DIV), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE(1'b1)) u_d1 (
    .clk(clk), .reset(reset), .x(x[1]), .y(y[1]), .video_on(vo[1]), .hsync(hs[1]),
    .vsync(vs[1]), .p_tick(pt[1]), .frame_tick(ft[1]), .frame_cnt(fc[1]));
  vga_sync #(.CLK_DIV(1), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE(1'b0)) u_d2 (
    .clk(clk), .reset(reset), .x(x[2]), .y(y[2]), .video_on(vo[2]), .hsync(hs[2]),
    .vsync(vs[2]), .p_tick(pt[2]), .frame_tick(ft[2]), .frame_cnt(fc[2]));

  // Reference: t clocks after reset release the DUT shows pixel number t/div of an endless raster.
  function automatic obs_t model(int i, int t, logic r);
    int d, hd, hf, hsw, hb, vd, vf, vsw, vb, ht, vt, p, pix, xx, yy;
    logic sa;
    obs_t o;
    if (i == 0) begin
      d = 4; hd = 640; hf = 16; hsw = 96; hb = 48; vd = 480; vf = 10; vsw = 2; vb = 33; sa = 1'b0;
    end else begin
      d = (i == 1) ? S_DIV : 1; hd = S_HD; hf = S_HF; hsw = S_HS; hb = S_HB;
      vd = S_VD; vf = S_VF; vsw = S_VS; vb = S_VB; sa = (i == 1);
    end
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    p = r ? 0 : t / d;
    pix = p % (ht * vt);
    xx = pix % ht;
    yy = pix / ht;
    o.x = 10'(xx);
    o.y = 10'(yy);
    o.vo = xx < hd && yy < vd;
    o.hs = (xx >= hd + hf && xx < hd + hf + hsw) ? sa : !sa;
    o.vs = (yy >= vd + vf && yy < vd + vf + vsw) ? sa : !sa;
    o.pt = !r && (t % d == d - 1);
    o.ft = !r && (t % d == 0) && p > 0 && pix == 0;
`ifdef VGA_SYNC_FRAME_CNT_EN
    o.fc = 16'((p / (ht * vt)) % 65536);
`else
    o.fc = '0;
`endif
    return o;
  endfunction

  function automatic obs_t snap(int i);
    return {x[i], y[i], vo[i], hs[i], vs[i], pt[i], ft[i], fc[i]};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      obs_t a = snap(i), e = model(i, n, reset);
      tests++;
      if (a !== e) begin fails++; $display("FAIL reset dut%0d got=%h exp=%h", i, a, e); end
    end
    @(negedge clk) reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      obs_t a = snap(i), e = model(i, n, reset);
      tests++;
      if (a !== e) begin fails++; $display("FAIL release dut%0d got=%h exp=%h", i, a, e); end
    end
  endtask

  task automatic test_first_tick;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        obs_t a = snap(i), e = model(i, n, reset);
        tests++;
        if (a !== e) begin fails++; $display("FAIL first_tick dut%0d n=%0d got=%h exp=%h", i, n, a, e); end
      end
    end
  endtask

  task automatic test_frames;
    int ft_cnt = 0, last = -1, period = -1;
    while (n < 1628) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        obs_t a = snap(i), e = model(i, n, reset);
        tests++;
        if (a !== e) begin fails++; $display("FAIL frames dut%0d n=%0d got=%h exp=%h", i, n, a, e); end
      end
      if (ft[1]) begin
        ft_cnt++;
        if (last >= 0) period = n - last;
        last = n;
      end
    end
    tests++;
    if (ft_cnt !== 3) begin fails++; $display("FAIL frame_tick_count got=%0d exp=3", ft_cnt); end
    tests++;
    if (period !== 540) begin fails++; $display("FAIL frame_period got=%0d exp=540", period); end
    tests++;
`ifdef VGA_SYNC_FRAME_CNT_EN
    if (fc[1] !== 16'd3) begin fails++; $display("FAIL frame_cnt got=%0d exp=3", fc[1]); end
`else
    if (fc[1] !== 16'd0) begin fails++; $display("FAIL frame_cnt got=%0d exp=0", fc[1]); end
`endif
  endtask

  task automatic test_line;
    int hs_low = 0, x_fall = -1, x_rise = -1, x_vo = -1;
    logic hs_prev = hs[0], vo_prev = vo[0];
    while (n < 6400) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        obs_t a = snap(i), e = model(i, n, reset);
        tests++;
        if (a !== e) begin fails++; $display("FAIL line dut%0d n=%0d got=%h exp=%h", i, n, a, e); end
      end
      if (n >= 3200) begin
        if (!hs[0]) hs_low++;
        if (hs_prev && !hs[0]) x_fall = int'(x[0]);
        if (!hs_prev && hs[0]) x_rise = int'(x[0]);
        if (vo_prev && !vo[0]) x_vo = int'(x[0]);
      end
      hs_prev = hs[0];
      vo_prev = vo[0];
    end
    tests++;
    if (hs_low !== 384) begin fails++; $display("FAIL hsync_width got=%0d exp=384", hs_low); end
    tests++;
    if (x_fall !== 656) begin fails++; $display("FAIL hsync_fall_x got=%0d exp=656", x_fall); end
    tests++;
    if (x_rise !== 752) begin fails++; $display("FAIL hsync_rise_x got=%0d exp=752", x_rise); end
    tests++;
    if (x_vo !== 640) begin fails++; $display("FAIL video_off_x got=%0d exp=640", x_vo); end
  endtask

  task automatic test_mid_reset;
    for (int k = 0; k < 4; k++) begin
      int len = int'($urandom_range(20, 700));
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          obs_t a = snap(i), e = model(i, n, reset);
          tests++;
          if (a !== e) begin fails++; $display("FAIL run dut%0d n=%0d got=%h exp=%h", i, n, a, e); end
        end
      end
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
        obs_t a = snap(i), e = model(i, 0, 1'b1);
        tests++;
        if (a !== e) begin fails++; $display("FAIL async_reset dut%0d got=%h exp=%h", i, a, e); end
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        obs_t a = snap(i), e = model(i, 0, 1'b1);
        tests++;
        if (a !== e) begin fails++; $display("FAIL reset_hold dut%0d got=%h exp=%h", i, a, e); end
      end
      @(negedge clk) reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          obs_t a = snap(i), e = model(i, n, reset);
          tests++;
          if (a !== e) begin fails++; $display("FAIL restart dut%0d n=%0d got=%h exp=%h", i, n, a, e); end
        end
      end
    end
  endtask

  task automatic test_clkdiv1;
    logic [9:0] prev = x[2];
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      tests++;
      if (pt[2] !== 1'b1) begin fails++; $display("FAIL div1_p_tick n=%0d got=%b exp=1", n, pt[2]); end
      tests++;
      if (x[2] !== 10'((int'(prev) + 1) % 15)) begin
        fails++; $display("FAIL div1_x_step n=%0d got=%0d exp=%0d", n, x[2], (int'(prev) + 1) % 15);
      end
      prev = x[2];
    end
  endtask

  initial begin
    test_reset;
    test_first_tick;
    test_frames;
    test_line;
    test_mid_reset;
    test_clkdiv1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
